// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   state_e : fetch controller states (encoding fixed: FETCH=0, WAIT=1, DRAIN=2)
//   PcInc   : byte distance between consecutive sequential fetches
package fetch_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam int unsigned PcInc = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {PC, instr} holding register used while decode is stalled.
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   load_i              : capture pc_i/instr_i and mark the entry valid
//   unload_i, clear_i   : drop the entry (unload = consumed, clear = flushed)
//   pc_i, instr_i       : data to capture
//   valid_o, pc_o, instr_o : held entry
module fetch_skid_buf #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               clear_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      if (clear_i || unload_i) begin
        valid_q <= 1'b0;
      end else if (load_i) begin
        valid_q <= 1'b1;
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: holds the PC, issues single-outstanding requests to
// instruction memory and presents fetched instructions to decode.
//   clk, reset                     : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      : request channel (valid/ready)
//   imem_resp_valid/data           : response channel (valid only)
//   PC_out, instr_out, pipeline_out_valid : presented instruction
//   stall                          : decode cannot accept, outputs hold
//   flush, flush_target            : discard in-flight work, redirect the PC
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic [ADDR_W-1:0]  PC_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               pipeline_out_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_target
);

  localparam int unsigned ADDR_SIZE  = ADDR_W - 1;
  localparam int unsigned INSTR_SIZE = INSTR_W - 1;

  state_e               state_q, state_d;
  logic [ADDR_SIZE:0]   pc_q, pc_d;
  logic                 out_valid_q, out_valid_d;
  logic [ADDR_SIZE:0]   pc_out_q, pc_out_d;
  logic [INSTR_SIZE:0]  instr_out_q, instr_out_d;

  logic                 handshake;
  logic                 resp_capture;
  logic                 skid_valid, skid_load, skid_unload;
  logic [ADDR_SIZE:0]   skid_pc;
  logic [INSTR_SIZE:0]  skid_instr;

  // Targets are forced to word alignment, so the low bits are never used.
  logic unused_flush_lsbs;
  assign unused_flush_lsbs = ^flush_target[1:0];

  // No new request while the skid is full: that bounds arrivals during a stall to one.
  assign imem_req_valid = !reset && (state_q == StFetch) && !skid_valid;
  assign imem_req_addr  = pc_q;
  assign handshake      = imem_req_valid && imem_req_ready;
  // A response arriving together with a flush belongs to the old stream and is dropped.
  assign resp_capture   = (state_q == StWait) && imem_resp_valid && !flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StFetch: if (handshake) state_d = flush ? StDrain : StWait;
      StWait: begin
        if (flush)                state_d = imem_resp_valid ? StFetch : StDrain;
        else if (imem_resp_valid) state_d = StFetch;
      end
      // A flush here only moves the PC; the stale response is still awaited.
      StDrain: if (imem_resp_valid) state_d = StFetch;
      default: state_d = StFetch;
    endcase
    if (flush) begin
      pc_d = {flush_target[ADDR_SIZE:2], 2'b00};
    end else if (resp_capture) begin
      pc_d = pc_q + ADDR_W'(PcInc);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    pc_out_d    = pc_out_q;
    instr_out_d = instr_out_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (stall && out_valid_q) begin
      skid_load = resp_capture;
    end else if (skid_valid) begin
      out_valid_d = 1'b1;
      pc_out_d    = skid_pc;
      instr_out_d = skid_instr;
      skid_unload = 1'b1;
    end else if (resp_capture) begin
      out_valid_d = 1'b1;
      pc_out_d    = pc_q;
      instr_out_d = imem_resp_data;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      pc_out_q    <= '0;
      instr_out_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      pc_out_q    <= pc_out_d;
      instr_out_q <= instr_out_d;
    end
  end

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (flush),
    .pc_i     (pc_q),
    .instr_i  (imem_resp_data),
    .valid_o  (skid_valid),
    .pc_o     (skid_pc),
    .instr_o  (skid_instr)
  );

  assign PC_out             = pc_out_q;
  assign instr_out          = instr_out_q;
  assign pipeline_out_valid = out_valid_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: a per-cycle vector table driving the
// memory/decode side by hand, followed by hand-written corner sequences.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] PC_out;
  logic [31:0] instr_out;
  logic        pipeline_out_valid;
  logic        stall;
  logic        flush;
  logic [31:0] flush_target;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_resp_valid    (imem_resp_valid),
    .imem_resp_data     (imem_resp_data),
    .PC_out             (PC_out),
    .instr_out          (instr_out),
    .pipeline_out_valid (pipeline_out_valid),
    .stall              (stall),
    .flush              (flush),
    .flush_target       (flush_target)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        st;
    logic        fl;
    logic [31:0] ft;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_in;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic rdy, rv, input logic [31:0] rd, input logic st, fl,
                              input logic [31:0] ft, input logic e_req,
                              input logic [31:0] e_addr, input logic e_ov,
                              input logic [31:0] e_pc, e_in);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.st = st; v.fl = fl; v.ft = ft;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_in = e_in;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next cycle (past one rising edge) and apply this cycle's inputs.
  task automatic drive(input logic rdy, rv, input logic [31:0] rd, input logic st, fl,
                       input logic [31:0] ft);
    @(negedge clk);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    stall           = st;
    flush           = fl;
    flush_target    = ft;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [31:0] pc, ins);
    chk({tag, ".valid"}, {31'b0, pipeline_out_valid}, {31'b0, ov});
    chk({tag, ".pc"}, PC_out, pc);
    chk({tag, ".instr"}, instr_out, ins);
  endtask

  task automatic chk_req(input string tag, input logic rv, input logic [31:0] addr);
    chk({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, rv});
    chk({tag, ".req_addr"}, imem_req_addr, addr);
  endtask

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    stall = 1'b0; flush = 1'b0; flush_target = '0;

    //           rdy  rv  rd            st fl ft            req addr          ov  pc            in
    tbl[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,      1, 32'h0,      0, 32'h0,      32'h0);
    tbl[1]  = mk(0, 1, 32'h13,        0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      32'h0);
    tbl[2]  = mk(1, 0, 32'h0,         0, 0, 32'h0,      1, 32'h4,      1, 32'h0,      32'h13);
    tbl[3]  = mk(0, 1, 32'h13,        0, 0, 32'h0,      0, 32'h4,      0, 32'h0,      32'h13);
    tbl[4]  = mk(1, 0, 32'h0,         0, 0, 32'h0,      1, 32'h8,      1, 32'h4,      32'h13);
    tbl[5]  = mk(0, 1, 32'h13,        0, 0, 32'h0,      0, 32'h8,      0, 32'h4,      32'h13);
    tbl[6]  = mk(1, 0, 32'h0,         1, 0, 32'h0,      1, 32'hC,      1, 32'h8,      32'h13);
    tbl[7]  = mk(0, 1, 32'h13,        1, 0, 32'h0,      0, 32'hC,      1, 32'h8,      32'h13);
    tbl[8]  = mk(1, 0, 32'h0,         1, 0, 32'h0,      0, 32'h10,     1, 32'h8,      32'h13);
    tbl[9]  = mk(1, 0, 32'h0,         1, 0, 32'h0,      0, 32'h10,     1, 32'h8,      32'h13);
    tbl[10] = mk(1, 0, 32'h0,         0, 0, 32'h0,      0, 32'h10,     1, 32'h8,      32'h13);
    tbl[11] = mk(1, 0, 32'h0,         0, 0, 32'h0,      1, 32'h10,     1, 32'hC,      32'h13);
    tbl[12] = mk(0, 0, 32'h0,         0, 1, 32'h100,    0, 32'h10,     0, 32'hC,      32'h13);
    tbl[13] = mk(0, 0, 32'h0,         0, 0, 32'h0,      0, 32'h100,    0, 32'hC,      32'h13);
    tbl[14] = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,      0, 32'h100,    0, 32'hC,      32'h13);
    tbl[15] = mk(1, 0, 32'h0,         0, 0, 32'h0,      1, 32'h100,    0, 32'hC,      32'h13);
    tbl[16] = mk(0, 1, 32'h00A0_0093, 0, 0, 32'h0,      0, 32'h100,    0, 32'hC,      32'h13);
    tbl[17] = mk(0, 0, 32'h0,         0, 0, 32'h0,      1, 32'h104,    1, 32'h100,    32'h00A0_0093);
    tbl[18] = mk(0, 0, 32'h0,         0, 0, 32'h0,      1, 32'h104,    0, 32'h100,    32'h00A0_0093);
    tbl[19] = mk(0, 0, 32'h0,         0, 0, 32'h0,      1, 32'h104,    0, 32'h100,    32'h00A0_0093);
    tbl[20] = mk(1, 0, 32'h0,         0, 0, 32'h0,      1, 32'h104,    0, 32'h100,    32'h00A0_0093);
    tbl[21] = mk(0, 1, 32'h13,        0, 0, 32'h0,      0, 32'h104,    0, 32'h100,    32'h00A0_0093);
    tbl[22] = mk(0, 0, 32'h0,         0, 1, 32'h103,    1, 32'h108,    1, 32'h104,    32'h13);
    tbl[23] = mk(0, 0, 32'h0,         0, 0, 32'h0,      1, 32'h100,    0, 32'h104,    32'h13);

    // Reset state while reset is held.
    #12;
    chk_req("reset", 1'b0, 32'h0);
    chk_out("reset", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].st, tbl[i].fl, tbl[i].ft);
      chk_req(tag, tbl[i].e_req, tbl[i].e_addr);
      chk_out(tag, tbl[i].e_ov, tbl[i].e_pc, tbl[i].e_in);
    end

    // Flush together with stall while output valid and skid full.
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    reset = 1'b0;
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    drive(0, 1, 32'h11, 0, 0, 32'h0);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk_out("fs.pre", 1'b1, 32'h0, 32'h11);
    chk_req("fs.pre", 1'b1, 32'h4);
    drive(0, 1, 32'h22, 1, 0, 32'h0);
    drive(1, 0, 32'h0, 1, 1, 32'h200);
    chk_req("fs.skidfull", 1'b0, 32'h8);
    chk_out("fs.skidfull", 1'b1, 32'h0, 32'h11);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk("fs.valid_cleared", {31'b0, pipeline_out_valid}, 32'h0);
    chk_req("fs.target", 1'b1, 32'h200);
    drive(0, 1, 32'h33, 0, 0, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk_out("fs.first", 1'b1, 32'h200, 32'h33);

    // PC wrap at the top of the address space.
    drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    chk_req("wrap.req", 1'b1, 32'hFFFF_FFFC);
    drive(0, 1, 32'h44, 0, 0, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk_out("wrap.out", 1'b1, 32'hFFFF_FFFC, 32'h44);
    chk_req("wrap.next", 1'b1, 32'h0);

    // Asynchronous reset between edges while a request is outstanding.
    drive(0, 0, 32'h0, 0, 1, 32'h40);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    drive(0, 1, 32'h1234, 0, 0, 32'h0);
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    chk_out("ar.pre", 1'b1, 32'h40, 32'h1234);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk_req("ar.wait", 1'b0, 32'h44);
    #2;
    reset = 1'b1;
    #1;
    chk_req("ar.inreset", 1'b0, 32'h0);
    chk_out("ar.inreset", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk_req("ar.after", 1'b1, 32'h0);
    chk("ar.after.valid", {31'b0, pipeline_out_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch stage and producer side of the fetch→decode pipeline interface (PC/instr/valid, stall, flush).
- Holds the PC and issues single-outstanding requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents fetched instructions to decode one per transfer.
- Supports back-pressure via stall and redirection via flush plus flush_target.

Parameters:
ADDR_W, 32, PC / memory address width
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  request to instruction memory
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  ADDR_W  word-aligned fetch address
imem_resp_valid  input  1  response data valid this cycle
imem_resp_data  input  INSTR_W  fetched instruction
PC_out  output  ADDR_W  PC of presented instruction
instr_out  output  INSTR_W  presented instruction
pipeline_out_valid  output  1  PC_out/instr_out valid
stall  input  1  decode cannot accept; hold outputs
flush  input  1  discard in-flight work, redirect
flush_target  input  ADDR_W  new PC on flush

Behaviour:
- Transfer rule: an instruction is consumed at a rising edge where pipeline_out_valid=1 and stall=0. While stall=1, PC_out, instr_out and pipeline_out_valid hold.
- Reset (async): state=FETCH, pc=RESET_PC, pipeline_out_valid=0, skid_valid=0, imem_req_valid=0 while reset is high, PC_out=0, instr_out=0.
- State FETCH:
  - imem_req_valid=1 iff skid_valid=0; imem_req_addr=pc.
  - Request handshake (req_valid & req_ready) → WAIT; pc unchanged until the response arrives.
- State WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: capture {pc, data}, pc<=pc+4 (wraps modulo 2^ADDR_W), → FETCH.
- State DRAIN:
  - Entered on flush while a request is outstanding.
  - imem_req_valid=0; the next imem_resp_valid is discarded; → FETCH.
- Output register update, evaluated at each edge in priority order:
  1. flush: pipeline_out_valid<=0, skid_valid<=0.
  2. stall=1 and pipeline_out_valid=1: hold; a captured response goes to the skid (skid_valid<=1).
  3. skid_valid: move skid to output, skid_valid<=0; a same-cycle response cannot occur because no request is issued while the skid is full.
  4. Captured response: load output, valid<=1.
  5. Otherwise: pipeline_out_valid<=0.
  - When pipeline_out_valid=0, stall does not block loading.
- Flush, sampled synchronously at clk; priority over stall and response:
  - pc <= {flush_target[ADDR_W-1:2], 2'b00}.
  - In FETCH with a handshake in the same cycle → DRAIN.
  - In WAIT without imem_resp_valid → DRAIN.
  - In WAIT with imem_resp_valid → response dropped, → FETCH.
  - In DRAIN → stay in DRAIN; pc is updated.
- Latency with zero-wait memory (ready=1, resp the cycle after acceptance):
  - Request accepted at edge N.
  - Response captured at edge N+1.
  - pipeline_out_valid high after edge N+1.
  - Next request issued in cycle N+1; throughput is one instruction per 2 cycles.
- Skid buffer: exactly one entry; at most one response can arrive while stalled because only one request is outstanding.
- Reset mid-transaction: the outstanding response after reset is not tracked. Memory must be reset together with this block.

Decomposition:
- Shared params file: ADDR_SIZE/INSTR_SIZE macros (MSB indices, equal to ADDR_W-1/INSTR_W-1), RESET_PC macro, PC increment constant 4.
- Local state encoding: FETCH=2'd0, WAIT=2'd1, DRAIN=2'd2.
- Optional sub-module fetch_skid_buf: the one-entry {PC, instr} holding register with load/unload/clear.
- Under SIMULATE: per-cycle display of PC_out/instr_out when valid, and a flush message.

Test Plan:
- Reset, zero-wait memory returning 32'h0000_0013 for every address → requests at 0x0, 0x4, 0x8; outputs (0x0,0x13), (0x4,0x13) valid every second cycle; imem_req_addr bits[1:0] always 0.
- Stall held 4 cycles while output shows PC 0x8 and the next response (PC 0xC) arrives → output holds 0x8; skid holds 0xC; imem_req_valid=0 during stall. After release: 0xC presented next cycle, then request for 0x10.
- Flush with flush_target=0x100 while in WAIT, response arriving 2 cycles later with 32'hDEAD_BEEF → response dropped, pipeline_out_valid=0, next request addr 0x100, first presented PC 0x100.
- Flush and stall together with output valid and skid full → output valid=0, skid cleared, next request at target; stall ignored for the flush.
- imem_req_ready low 3 cycles → imem_req_valid and addr stay stable; no state change; first transfer after ready rises.
- flush_target=0x103 → request addr 0x100. PC 0xFFFF_FFFC fetch → next PC 0x0000_0000.
- Async reset asserted between clock edges mid-WAIT → all outputs zero immediately; after deassert, first request addr RESET_PC.
